div_unit: RTL and testbench

- Multi-cycle signed 32-bit integer divider.
- Responder to the control unit's div start/done handshake.
- Quotient feeds the Lo register path; remainder feeds the Hi register path, both through the existing Hi/Lo select muxes.
- Operands come from the A and B registers; a div-by-zero indication goes to the control unit for exception handling.

---
 rtl/div_unit_if.sv | 29 ++
 rtl/div_unit.sv | 120 ++++++++++++
 tb/tb_div_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Start/done handshake and operand/result bus between the control unit and div_unit.
// DIV_UNSIGNED_EN adds the is_unsigned request qualifier.
interface div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
`ifdef DIV_UNSIGNED_EN
   logic             is_unsigned;
`endif
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

`ifdef DIV_UNSIGNED_EN
   modport master (output start, dividend, divisor, is_unsigned,
                   input  busy, done, div_zero, hi_out, lo_out);
   modport slave  (input  start, dividend, divisor, is_unsigned,
                   output busy, done, div_zero, hi_out, lo_out);
`else
   modport master (output start, dividend, divisor,
                   input  busy, done, div_zero, hi_out, lo_out);
   modport slave  (input  start, dividend, divisor,
                   output busy, done, div_zero, hi_out, lo_out);
`endif
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: signed 32-bit quotient (lo_out) and remainder (hi_out).
// Optional unsigned mode (divu) is enabled with DIV_UNSIGNED_EN.
module div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = 32
) (
   input  logic      clk,
   input  logic      reset,
   div_unit_if.slave bus
);
   localparam int unsigned CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic             q_neg, r_neg;

   logic             signed_op;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH-1:0] rem_nxt, quo_nxt;
   logic             accept, zero_hit, last;

`ifdef DIV_UNSIGNED_EN
   assign signed_op = ~bus.is_unsigned;
`else
   assign signed_op = 1'b1;
`endif

   // Magnitudes are unsigned, so 0x80000000 becomes 2^31 without overflow.
   always_comb begin
      a_neg = signed_op & bus.dividend[WIDTH-1];
      b_neg = signed_op & bus.divisor[WIDTH-1];
      a_mag = a_neg ? -bus.dividend : bus.dividend;
      b_mag = b_neg ? -bus.divisor  : bus.divisor;
   end

   // One restoring step; the 33-bit compare covers the carry out of the shift.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      ge      = shifted >= {1'b0, dvsr};
      rem_nxt = ge ? WIDTH'(shifted - {1'b0, dvsr}) : shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], ge};
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      zero_hit  = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  zero_hit = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = CALC;
               end
            end
         end
         CALC: begin
            if (count == CW'(ITER - 1)) begin
               last      = 1'b1;
               state_nxt = FINISH;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= '0;
         rem          <= '0;
         quo          <= '0;
         dvsr         <= '0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.div_zero <= 1'b0;
         bus.hi_out   <= '0;
         bus.lo_out   <= '0;
      end else begin
         bus.busy     <= (state_nxt == CALC);
         bus.done     <= last;
         bus.div_zero <= zero_hit;
         if (accept) begin
            count <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvsr  <= b_mag;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
         end else if (state == CALC) begin
            count <= count + 1'b1;
            rem   <= rem_nxt;
            quo   <= quo_nxt;
         end
         // Results are taken straight from the final step so they are valid with done.
         if (last) begin
            bus.lo_out <= q_neg ? -quo_nxt : quo_nxt;
            bus.hi_out <= r_neg ? -rem_nxt : rem_nxt;
         end
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_div_unit;
   logic clk;
   logic reset;
   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] last_lo, last_hi;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit uns,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (uns) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
   endfunction

   task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit uns);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
`ifdef DIV_UNSIGNED_EN
      bus.is_unsigned = uns;
`else
      if (uns) $display("unsigned request ignored in signed-only build");
`endif
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Observes cycles N+1.. after acceptance; optional extra start pulse or reset in CALC.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit uns, input int unsigned poke_at, input int unsigned rst_at);
      logic [31:0] eq, er;
      int unsigned busy_cnt, done_cnt, done_at, window;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      window   = (poke_at != 0 || rst_at != 0) ? 45 : 33;
      model(a, b, uns, eq, er);
      drive_start(a, b, uns);
      for (int unsigned k = 1; k <= window; k++) begin
         if (k > 1) @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_at == 0) done_at = k;
         end
         if (k == 20 && rst_at == 0) begin
            check({tag, " lo held in CALC"}, bus.lo_out, last_lo);
            check({tag, " hi held in CALC"}, bus.hi_out, last_hi);
         end
         if (rst_at != 0 && k == rst_at + 1) begin
            check({tag, " busy after reset"}, 32'(bus.busy), 32'd0);
            check({tag, " done after reset"}, 32'(bus.done), 32'd0);
            check({tag, " div_zero after reset"}, 32'(bus.div_zero), 32'd0);
            check({tag, " lo after reset"}, bus.lo_out, 32'd0);
            check({tag, " hi after reset"}, bus.hi_out, 32'd0);
         end
         bus.start = (poke_at == k);
         if (poke_at == k) begin
            bus.dividend = 32'd1;
            bus.divisor  = 32'd1;
         end
         reset = (rst_at == k);
      end
      bus.start = 1'b0;
      reset     = 1'b0;
      if (rst_at != 0) begin
         check({tag, " done count"}, done_cnt, 0);
         last_lo = '0;
         last_hi = '0;
      end else begin
         check({tag, " done cycle"}, done_at, 33);
         check({tag, " done count"}, done_cnt, 1);
         check({tag, " busy cycles"}, busy_cnt, 32);
         check({tag, " lo"}, bus.lo_out, eq);
         check({tag, " hi"}, bus.hi_out, er);
         last_lo = eq;
         last_hi = er;
      end
   endtask

   task automatic run_zero(input string tag, input logic [31:0] a);
      int unsigned done_cnt, dz_cnt;
      done_cnt = 0; dz_cnt = 0;
      drive_start(a, 32'd0, 1'b0);
      check({tag, " div_zero pulse"}, 32'(bus.div_zero), 32'd1);
      for (int unsigned k = 2; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
         if (bus.div_zero) dz_cnt++;
      end
      check({tag, " div_zero width"}, dz_cnt, 0);
      check({tag, " no done"}, done_cnt, 0);
      check({tag, " lo kept"}, bus.lo_out, last_lo);
      check({tag, " hi kept"}, bus.hi_out, last_hi);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit ru;
      n_checks = 0;
      n_fail   = 0;
      last_lo  = '0;
      last_hi  = '0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
`ifdef DIV_UNSIGNED_EN
      bus.is_unsigned = 1'b0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset div_zero", 32'(bus.div_zero), 32'd0);
      check("reset hi", bus.hi_out, 32'd0);
      check("reset lo", bus.lo_out, 32'd0);

      run_div("100/7", 32'd100, 32'd7, 1'b0, 0, 0);
      run_div("-100/7", 32'hFFFF_FF9C, 32'd7, 1'b0, 0, 0);
      run_div("100/-7", 32'd100, 32'hFFFF_FFF9, 1'b0, 0, 0);
      run_zero("5/0", 32'd5);
      run_div("9/3", 32'd9, 32'd3, 1'b0, 0, 0);
      run_div("min/-1 poke", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 0);
      run_div("0/13", 32'd0, 32'd13, 1'b0, 0, 0);
      run_div("min/min", 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0);
      run_div("reset mid", 32'd1000, 32'd3, 1'b0, 0, 15);
      run_div("after reset", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 0, 0);
`ifdef DIV_UNSIGNED_EN
      run_div("divu fffffffe/2", 32'hFFFF_FFFE, 32'd2, 1'b1, 0, 0);
      run_div("divu max/7", 32'hFFFF_FFFF, 32'd7, 1'b1, 0, 0);
`endif

      for (int unsigned i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 40));
         if ($urandom_range(0, 3) == 0) rb = -rb;
         if (rb == 32'd0) rb = 32'd1;
`ifdef DIV_UNSIGNED_EN
         ru = 1'($urandom_range(0, 1));
`else
         ru = 1'b0;
`endif
         run_div("random", ra, rb, ru, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
